light_fsm: RTL and testbench

Traffic-light sequencing controller for the main/side intersection. It sits directly downstream of the timing-parameter store. It drives the 2-bit `interval` select into that store and consumes the 4-bit `value` it returns. It counts each phase down in seconds and drives the main-road and side-road lamps.

---
 rtl/light_pkg.sv | 65 ++++++
 rtl/light_fsm_tick_gen.sv | 28 ++
 rtl/light_fsm.sv | 118 +++++++++++
 tb/tb_light_fsm.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and encodings for the main/side traffic-light controller.
// The optional pedestrian phase is enabled with LIGHT_FSM_WALK_EN.
package light_pkg;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    SIDE_GRN = 3'd2,
    SIDE_EXT = 3'd3,
    SIDE_YEL = 3'd4
`ifdef LIGHT_FSM_WALK_EN
    ,
    WALK     = 3'd5
`endif
  } state_t;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_ZERO = 2'b11;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // An encoding outside the enum selects a zero-length duration.
  function automatic logic [1:0] state_interval(state_t s);
    logic [1:0] r;
    r = INT_ZERO;
    case (s)
      MAIN_GRN, SIDE_GRN: r = INT_BASE;
      MAIN_YEL, SIDE_YEL: r = INT_YEL;
      SIDE_EXT:           r = INT_EXT;
`ifdef LIGHT_FSM_WALK_EN
      WALK:               r = INT_EXT;
`endif
      default:            r = INT_ZERO;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] main_lamp(state_t s);
    logic [2:0] r;
    r = LAMP_R;
    case (s)
      MAIN_GRN: r = LAMP_G;
      MAIN_YEL: r = LAMP_Y;
      default:  r = LAMP_R;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] side_lamp(state_t s);
    logic [2:0] r;
    r = LAMP_R;
    case (s)
      SIDE_GRN, SIDE_EXT: r = LAMP_G;
      SIDE_YEL:           r = LAMP_Y;
      default:            r = LAMP_R;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/light_fsm_tick_gen.sv
// Free-running divider producing a one-cycle strobe every TICKS_PER_SEC cycles.
module tick_gen #(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_fsm.sv
// Main/side intersection sequencer: selects a duration, counts it down in ticks, drives lamps.
// Define LIGHT_FSM_WALK_EN to add the latched pedestrian request and the all-red WALK phase.
module light_fsm
  import light_pkg::*;
#(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       g_reset,
  input  logic       sensor,
`ifdef LIGHT_FSM_WALK_EN
  input  logic       walk_req,
  output logic       walk,
`endif
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       tick
);

  state_t     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] pend_q, pend_d;
  logic       running;
  logic       expire;
  logic       enter;
`ifdef LIGHT_FSM_WALK_EN
  logic       walk_lat_q, walk_lat_d;
  logic       walk_q, walk_d;
`endif

  tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick_gen (
    .clk  (clk),
    .rst  (g_reset),
    .tick (tick)
  );

  always_comb begin
    running = (pend_q == 2'b00);
    expire  = running && tick && (cnt_q <= 4'd1);
    enter   = expire;
    state_d = state_q;
    case (state_q)
      MAIN_GRN: if (expire) state_d = sensor ? MAIN_YEL : MAIN_GRN;
      MAIN_YEL: if (expire)
`ifdef LIGHT_FSM_WALK_EN
        state_d = walk_lat_q ? WALK : SIDE_GRN;
`else
        state_d = SIDE_GRN;
`endif
      SIDE_GRN: if (expire) state_d = sensor ? SIDE_EXT : SIDE_YEL;
      SIDE_EXT: if (expire) state_d = SIDE_YEL;
      SIDE_YEL: if (expire) state_d = MAIN_GRN;
`ifdef LIGHT_FSM_WALK_EN
      WALK:     if (expire) state_d = SIDE_GRN;
`endif
      default: begin
        state_d = MAIN_GRN;
        enter   = 1'b1;
      end
    endcase

    // The store answers one cycle after interval moves, so the load lands two edges after entry.
    pend_d = enter ? 2'b01 : {pend_q[0], 1'b0};
    cnt_d  = cnt_q;
    if (pend_q[1]) begin
      cnt_d = value;
    end else if (running && tick && !expire) begin
      cnt_d = cnt_q - 4'd1;
    end

    interval_d = state_interval(state_d);
    main_d     = main_lamp(state_d);
    side_d     = side_lamp(state_d);
`ifdef LIGHT_FSM_WALK_EN
    walk_d     = (state_d == WALK);
    walk_lat_d = (walk_d && (state_q != WALK)) ? 1'b0 : (walk_lat_q | walk_req);
`endif
  end

  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= MAIN_GRN;
      interval_q <= INT_BASE;
      main_q     <= LAMP_G;
      side_q     <= LAMP_R;
      cnt_q      <= 4'd0;
      pend_q     <= 2'b01;
`ifdef LIGHT_FSM_WALK_EN
      walk_q     <= 1'b0;
      walk_lat_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      main_q     <= main_d;
      side_q     <= side_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
`ifdef LIGHT_FSM_WALK_EN
      walk_q     <= walk_d;
      walk_lat_q <= walk_lat_d;
`endif
    end
  end

  assign interval    = interval_q;
  assign main_lights = main_q;
  assign side_lights = side_q;
`ifdef LIGHT_FSM_WALK_EN
  assign walk        = walk_q;
`endif

endmodule

// File: tb/tb_light_fsm.sv
// Bench for light_fsm: registered parameter-store model, phase-level reference model, per-scenario tasks.
module tb_light_fsm;

  localparam int TPS = 4;
  localparam int MG = 0, MY = 1, SG = 2, SE = 3, SY = 4, WK = 5;
  localparam logic [8:0] RST_VEC = {2'b00, 3'b001, 3'b100, 1'b0};

  logic       clk = 1'b0;
  logic       g_reset = 1'b1;
  logic       sensor = 1'b0;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] main_lights, side_lights;
  logic       tick;
`ifdef LIGHT_FSM_WALK_EN
  logic       walk_req = 1'b0;
  logic       walk;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] lut [4];

  always #5 clk = ~clk;

  light_fsm #(.TICKS_PER_SEC(TPS)) dut (
    .clk         (clk),
    .g_reset     (g_reset),
    .sensor      (sensor),
`ifdef LIGHT_FSM_WALK_EN
    .walk_req    (walk_req),
    .walk        (walk),
`endif
    .value       (value),
    .interval    (interval),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .tick        (tick)
  );

  // Upstream parameter store: registered lookup of the selected interval.
  always @(posedge clk) value <= lut[interval];

  // Reference model: phases measured in whole ticks, counted from the load two edges after entry.
  int         m_st, m_entry, m_edge, m_n;
  bit         m_loaded, m_walk;
  logic [3:0] m_value;

  function automatic logic [7:0] st_out(int s);
    logic [7:0] o;
    case (s)
      MG:      o = {2'b00, 3'b001, 3'b100};
      MY:      o = {2'b10, 3'b010, 3'b100};
      SG:      o = {2'b00, 3'b100, 3'b001};
      SE:      o = {2'b01, 3'b100, 3'b001};
      SY:      o = {2'b10, 3'b100, 3'b010};
      default: o = {2'b01, 3'b100, 3'b100};
    endcase
    return o;
  endfunction

  function automatic logic [1:0] st_int(int s);
    logic [7:0] o;
    o = st_out(s);
    return o[7:6];
  endfunction

  function automatic int next_st(int s);
    case (s)
      MG: return sensor ? MY : MG;
`ifdef LIGHT_FSM_WALK_EN
      MY: return m_walk ? WK : SG;
`else
      MY: return SG;
`endif
      SG: return sensor ? SE : SY;
      SE: return SY;
      SY: return MG;
      default: return SG;
    endcase
  endfunction

  always @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      m_st     <= MG;
      m_entry  <= 0;
      m_edge   <= 0;
      m_n      <= 0;
      m_loaded <= 1'b0;
      m_walk   <= 1'b0;
      m_value  <= lut[0];
    end else begin
      m_edge  <= m_edge + 1;
      m_value <= lut[st_int(m_st)];
`ifdef LIGHT_FSM_WALK_EN
      if (walk_req) m_walk <= 1'b1;
`endif
      if (m_edge + 1 == m_entry + 2) begin
        m_n      <= (m_value == 4'd0) ? 1 : int'(m_value);
        m_loaded <= 1'b1;
      end else if (m_loaded && ((m_edge + 1) % TPS == 0)) begin
        if (m_n == 1) begin
          m_st     <= next_st(m_st);
          m_entry  <= m_edge + 1;
          m_loaded <= 1'b0;
          if (next_st(m_st) == WK) m_walk <= 1'b0;
        end else begin
          m_n <= m_n - 1;
        end
      end
    end
  end

  function automatic logic [8:0] exp_vec();
    return {st_out(m_st), (m_edge % TPS == TPS - 1)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {interval, main_lights, side_lights, tick};
  endfunction

  // Phase monitor: records each completed visible phase as (interval, ticks seen after the load window).
  logic [7:0] mon_prev;
  int         mon_k, mon_t;
  logic [1:0] obs_int_q [$];
  int         obs_dw_q [$];

  always @(negedge clk) begin
    if (g_reset) begin
      mon_prev <= RST_VEC[8:1];
      mon_k    <= 0;
      mon_t    <= 0;
      obs_int_q.delete();
      obs_dw_q.delete();
    end else if ({interval, main_lights, side_lights} != mon_prev) begin
      obs_int_q.push_back(mon_prev[7:6]);
      obs_dw_q.push_back(mon_t);
      mon_prev <= {interval, main_lights, side_lights};
      mon_k    <= 0;
      mon_t    <= 0;
    end else begin
      mon_k <= mon_k + 1;
      if (mon_k + 1 >= 2 && tick) mon_t <= mon_t + 1;
    end
  end

  task automatic lut_default();
    lut[0] = 4'd6; lut[1] = 4'd3; lut[2] = 4'd2; lut[3] = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 g_reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 g_reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== RST_VEC) begin
        n_err++;
        $display("FAIL reset_hold @%0t: got %b want %b", $time, dut_vec(), RST_VEC);
      end
    end
    #1 g_reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_release @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sensor_low();
    lut_default(); sensor = 1'b0; do_reset();
    repeat (150) begin
      @(negedge clk);
      n_cmp += 2;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL low_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
      if (side_lights !== 3'b100) begin
        n_err++;
        $display("FAIL low_side_red @%0t: got %b want 100", $time, side_lights);
      end
    end
  endtask

  task automatic test_sensor_high();
    int ed [5];
    logic [1:0] ei [5];
    ed = '{6, 2, 6, 3, 2};
    ei = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    lut_default(); sensor = 1'b1; do_reset();
    for (int c = 0; c < 400 && obs_int_q.size() < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL high_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs_int_q.size() <= i) begin
        n_err++;
        $display("FAIL high_phase%0d: no phase seen, want interval %b for %0d ticks", i, ei[i], ed[i]);
      end else if (obs_int_q[i] !== ei[i] || obs_dw_q[i] != ed[i]) begin
        n_err++;
        $display("FAIL high_phase%0d: got interval %b for %0d ticks, want %b for %0d", i,
                 obs_int_q[i], obs_dw_q[i], ei[i], ed[i]);
      end
    end
  endtask

  task automatic test_sensor_drop();
    int ed [4];
    logic [1:0] ei [4];
    ed = '{6, 2, 6, 2};
    ei = '{2'b00, 2'b10, 2'b00, 2'b10};
    lut_default(); sensor = 1'b1; do_reset();
    for (int c = 0; c < 400 && obs_int_q.size() < 4; c++) begin
      @(negedge clk);
      if (m_st == SG) sensor = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL drop_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_int_q.size() <= i) begin
        n_err++;
        $display("FAIL drop_phase%0d: no phase seen, want interval %b for %0d ticks", i, ei[i], ed[i]);
      end else if (obs_int_q[i] !== ei[i] || obs_dw_q[i] != ed[i]) begin
        n_err++;
        $display("FAIL drop_phase%0d: got interval %b for %0d ticks, want %b for %0d", i,
                 obs_int_q[i], obs_dw_q[i], ei[i], ed[i]);
      end
    end
  endtask

  task automatic test_yel_short();
    for (int yv = 0; yv < 2; yv++) begin
      lut_default(); lut[2] = 4'(yv); sensor = 1'b1; do_reset();
      for (int c = 0; c < 300 && obs_int_q.size() < 2; c++) begin
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL yel%0d_cycle @%0t: got %b want %b", yv, $time, dut_vec(), exp_vec());
        end
      end
      n_cmp++;
      if (obs_int_q.size() < 2) begin
        n_err++;
        $display("FAIL yel%0d_dwell: yellow phase not seen, want 1 tick", yv);
      end else if (obs_int_q[1] !== 2'b10 || obs_dw_q[1] != 1) begin
        n_err++;
        $display("FAIL yel%0d_dwell: got interval %b for %0d ticks, want 10 for 1", yv,
                 obs_int_q[1], obs_dw_q[1]);
      end
    end
    lut_default();
  endtask

  task automatic test_reprogram();
    int want [3];
    int idx [3];
    want = '{6, 9, 9};
    idx  = '{0, 2, 5};
    lut_default(); sensor = 1'b1; do_reset();
    for (int c = 0; c < 500 && obs_int_q.size() < 6; c++) begin
      @(negedge clk);
      if (c == 8) lut[0] = 4'd9;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reprog_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_dw_q.size() <= idx[i]) begin
        n_err++;
        $display("FAIL reprog_phase%0d: no phase seen, want %0d ticks", idx[i], want[i]);
      end else if (obs_int_q[idx[i]] !== 2'b00 || obs_dw_q[idx[i]] != want[i]) begin
        n_err++;
        $display("FAIL reprog_phase%0d: got interval %b for %0d ticks, want 00 for %0d", idx[i],
                 obs_int_q[idx[i]], obs_dw_q[idx[i]], want[i]);
      end
    end
    lut_default();
  endtask

  task automatic test_reset_mid();
    int nt;
    lut_default(); sensor = 1'b1; do_reset();
    for (int c = 0; c < 400 && m_st != SE; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL mid_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
    nt = 0;
    for (int c = 0; c < 40 && nt < 3; c++) begin
      @(negedge clk);
      if (m_edge % TPS == TPS - 1) nt++;
    end
    n_cmp++;
    if (m_st != SE || dut_vec() !== {2'b01, 3'b100, 3'b001, 1'b1}) begin
      n_err++;
      $display("FAIL mid_in_ext: got %b want 011000011 before reset", dut_vec());
    end
    #1 g_reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL mid_async_reset @%0t: got %b want %b", $time, dut_vec(), RST_VEC);
    end
    repeat (2) @(negedge clk);
    #1 g_reset = 1'b0;
    for (int c = 0; c < 200 && obs_int_q.size() < 1; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL mid_restart @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (obs_int_q.size() < 1 || obs_dw_q[0] != 6) begin
      n_err++;
      $display("FAIL mid_first_phase: got %0d phases, want first main green of 6 ticks", obs_int_q.size());
    end
  endtask

  task automatic test_random();
    lut_default(); sensor = 1'b0; do_reset();
    repeat (800) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rand_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
      if ($urandom_range(0, 9) == 0) sensor = ~sensor;
      if ($urandom_range(0, 39) == 0) lut[$urandom_range(0, 2)] = 4'($urandom_range(0, 15));
    end
    lut_default();
  endtask

`ifdef LIGHT_FSM_WALK_EN
  task automatic test_walk();
    lut_default(); sensor = 1'b1; do_reset();
    for (int c = 0; c < 400 && obs_int_q.size() < 3; c++) begin
      @(negedge clk);
      walk_req = (c == 3);
      n_cmp += 2;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL walk_cycle @%0t: got %b want %b", $time, dut_vec(), exp_vec());
      end
      if (walk !== (m_st == WK)) begin
        n_err++;
        $display("FAIL walk_out @%0t: got %b want %b", $time, walk, (m_st == WK));
      end
    end
    walk_req = 1'b0;
    n_cmp++;
    if (obs_int_q.size() < 3 || obs_int_q[2] !== 2'b01 || obs_dw_q[2] != 3) begin
      n_err++;
      $display("FAIL walk_phase: got %0d phases, want third phase interval 01 for 3 ticks", obs_int_q.size());
    end
  endtask
`endif

  initial begin
    lut_default();
    test_reset();
    test_sensor_low();
    test_sensor_high();
    test_sensor_drop();
    test_yel_short();
    test_reprogram();
    test_reset_mid();
    test_random();
`ifdef LIGHT_FSM_WALK_EN
    test_walk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
